muldiv_sequencer: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit for the i16 core's execute stage.
- Computes MUL, MULHU, DIVU and REMU one bit per clock by time-sharing a single FullAdderSigned16bit instance as its only adder/subtractor.
- Sits beside the combinational ALU and is invoked for M-type ops; the core stalls on busy.

---
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative 16-bit unsigned MUL/MULHU/DIVU/REMU unit for the i16 execute stage.
// Produces one result bit per clock through a single shared 16-bit adder.

module FullAdderSigned16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        overflow
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    assign overflow    = (a[15] == b[15]) && (sum[15] != a[15]);
endmodule

module muldiv_sequencer #(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_r;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mq;
    logic [XLEN-1:0] mcand;

    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic            add_cin;
    logic [XLEN-1:0] add_sum;
    logic            add_cout;
    logic            unused_overflow;

    logic [XLEN-1:0] rem_shift;
    logic            take;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] mq_next;
    logic            div_by_zero;
    logic            last_iter;

    // acc doubles as the remainder, mq as the quotient and mcand as the divisor
    FullAdderSigned16bit adder (
        .a        (add_a),
        .b        (add_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (unused_overflow)
    );

    assign div_by_zero = op[1] && (b == '0);
    assign last_iter   = (cnt == CW'(XLEN - 1));
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_comb begin
        rem_shift = {acc[XLEN-2:0], mq[XLEN-1]};
        add_a     = acc;
        add_b     = mq[0] ? mcand : '0;
        add_cin   = 1'b0;
        take      = 1'b0;
        acc_next  = {add_cout, add_sum[XLEN-1:1]};
        mq_next   = {add_sum[0], mq[XLEN-1:1]};
        if (op_r[1]) begin
            add_a    = rem_shift;
            add_b    = ~mcand;
            add_cin  = 1'b1;
            take     = acc[XLEN-1] | add_cout;
            acc_next = take ? add_sum : rem_shift;
            mq_next  = {mq[XLEN-2:0], take};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = div_by_zero ? DONE : RUN;
            RUN:  if (last_iter) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // op[0] selects the upper register (MULHU, REMU) over the lower one (MUL, DIVU)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_r   <= '0;
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        cnt   <= '0;
                        acc   <= '0;
                        mq    <= a;
                        mcand <= b;
                        if (div_by_zero) result <= op[0] ? a : '1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_next;
                    mq  <= mq_next;
                    if (last_iter) result <= op_r[0] ? acc_next : mq_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, expected results
// queued at issue and checked by a monitor whenever done pulses.

module tb_muldiv_sequencer;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Latency is the index of the done cycle counted from the acceptance edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_done: got done=1 result=%0h, want no done", result);
                end else begin
                    e = sb.pop_front();
                    check_output({e.name, "_result"}, 32'(result), 32'(e.res));
                    check_output({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL idle_timeout: got busy=1, want busy=0");
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [1:0] op_i, input logic [15:0] a_i,
                                  input logic [15:0] b_i, input logic [15:0] res, input int lat);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        e.res = res; e.lat = lat; e.acc = cyc + 1; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    initial begin
        exp_t e;
        int   n;
        bit   second_issued;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        fork
            monitor();
        join_none

        @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_result", 32'(result), 32'h0);
        rst = 1'b0;

        apply_stimulus("mul_1234x10",    OP_MUL,   16'h1234, 16'h0010, 16'h2340, 17);
        apply_stimulus("mulhu_1234x10",  OP_MULHU, 16'h1234, 16'h0010, 16'h0001, 17);
        apply_stimulus("mul_ffffxffff",  OP_MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 17);
        apply_stimulus("mulhu_ffffxffff",OP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
        apply_stimulus("mul_0x1234",     OP_MUL,   16'h0000, 16'h1234, 16'h0000, 17);
        apply_stimulus("mulhu_abcdx0",   OP_MULHU, 16'hABCD, 16'h0000, 16'h0000, 17);
        apply_stimulus("divu_100_7",     OP_DIVU,  16'd100,  16'd7,    16'h000E, 17);
        apply_stimulus("remu_100_7",     OP_REMU,  16'd100,  16'd7,    16'h0002, 17);
        apply_stimulus("divu_ffff_1",    OP_DIVU,  16'hFFFF, 16'h0001, 16'hFFFF, 17);
        apply_stimulus("remu_5_9",       OP_REMU,  16'h0005, 16'h0009, 16'h0005, 17);
        apply_stimulus("divu_by_zero",   OP_DIVU,  16'h1234, 16'h0000, 16'hFFFF, 1);
        apply_stimulus("remu_by_zero",   OP_REMU,  16'h1234, 16'h0000, 16'h1234, 1);

        // start held high across a whole op while the operands churn
        wait_idle();
        start = 1'b1; op = OP_MUL; a = 16'd3; b = 16'd5;
        e.res = 16'h000F; e.lat = 17; e.acc = cyc + 1; e.name = "held_first";
        sb.push_back(e);
        second_issued = 1'b0;
        n = 0;
        while (!second_issued && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = 16'd7; b = 16'd9;
                e.res = 16'h003F; e.lat = 17; e.acc = cyc + 1; e.name = "held_second";
                sb.push_back(e);
                second_issued = 1'b1;
            end
        end
        if (!second_issued) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL held_second_issue: got busy=%0b, want idle within 60 cycles", busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;

        // asynchronous reset in the middle of a divide
        wait_idle();
        start = 1'b1; op = OP_DIVU; a = 16'd100; b = 16'd7;
        e.res = 16'h000E; e.lat = 17; e.acc = cyc + 1; e.name = "aborted_div";
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_result", 32'(result), 32'h0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        check_output("abort_no_busy", 32'(busy), 32'd0);

        apply_stimulus("divu_after_reset", OP_DIVU, 16'd100, 16'd7, 16'h000E, 17);

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
